uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter for the MARVIN utils layer. It consumes the one-cycle baud enable produced by the clock-enable generator (`ckegen1`, with `T` = clk_freq / baud) and shifts out parallel bytes as asynchronous serial frames. Upstream logic supplies bytes through a valid/ready handshake. All bit boundaries align to the enable pulse, so every serial bit lasts exactly one enable period.

## Interface
Parameters:
- `DATA_BITS`, default 8: payload width; legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `tick`, in, 1: baud enable; high for one clk cycle per bit period.
- `data`, in, `DATA_BITS`: payload; sampled on handshake.
- `valid`, in, 1: upstream holds `data`.
- `ready`, out, 1: block can accept; transfer occurs when `valid && ready` at a posedge.
- `tx`, out, 1: serial line; idle high; registered.
- `busy`, out, 1: a frame is pending or on the line.

## Operation
- States:
  - IDLE: waiting for a handshake.
  - WAIT: byte accepted, waiting for the next tick.
  - START: start bit (`tx` = 0).
  - DATA: payload bits, LSB first.
  - PAR: parity bit.
  - STOP: stop bit(s) (`tx` = 1).
- IDLE -> WAIT on handshake. The shift register loads `data`; parity is computed from the loaded value.
- Every transition after WAIT happens only on a clk edge where `tick` = 1. Between ticks, state and `tx` hold.
- WAIT -> START on tick.
- START -> DATA on tick.
- DATA -> PAR or STOP on the tick that ends bit `DATA_BITS-1`. The bit counter runs 0..`DATA_BITS-1` and then wraps to 0.
- PAR -> STOP on tick. PAR is skipped when `PARITY` = 0.
  - Even parity bit = XOR of the payload.
  - Odd parity bit = inverted XOR of the payload.
- STOP -> IDLE on the tick that ends the final stop bit. When `STOP_BITS` = 2, the stop counter holds the state for 2 ticks.
- `ready` = (state == IDLE) && !rst. It is combinational from registered state.
- `busy` = (state != IDLE). It is combinational from registered state.
- A tick arriving in IDLE is ignored.
- A tick in the same cycle as the handshake is ignored; the frame waits for the next tick.
- `valid` held high continuously: the next byte is accepted in the first IDLE cycle after the stop bit(s). Because of the WAIT state, the gap between frames is 1..T cycles of extra idle-high.
- Changes to `valid`/`data` outside a handshake have no effect.

## Timing
- Reset values:
  - state = IDLE
  - `tx` = 1
  - `busy` = 0
  - `ready` = 0 while `rst` is high, 1 from the first cycle after release
  - shift register and counters = 0
- `rst` asserted mid-frame:
  - `tx` returns high immediately (asynchronously); the frame is aborted.
  - No partial frame resumes after release.
- Latency:
  - Handshake at cycle a, next tick at cycle t > a: `tx` falls at cycle t+1.
  - Each bit is held for exactly one tick period T.
- Frame length N = 1 + `DATA_BITS` + (`PARITY` != 0) + `STOP_BITS` bit periods.
- `ready` rises the cycle after the tick that closes the last stop bit, i.e. t + N·T + 1.
- `busy` is high from cycle a+1 through the cycle of that final tick.

## Structure
- Package `uart_pkg`:
  - `uart_state_t` enum (IDLE, WAIT, START, DATA, PAR, STOP).
  - Parity constants `PAR_NONE` = 0, `PAR_EVEN` = 1, `PAR_ODD` = 2.
- Single module with no sub-module. The bit counter is `$clog2(DATA_BITS)` wide.
- The tick source is instantiated by the parent, not inside this block.
- Elaboration check rejects `DATA_BITS` outside 5..9, `STOP_BITS` outside 1..2, and `PARITY` > 2.

## Test plan
- Common bench setup: `ckegen1` with T = 4 drives `tick`.
- 8N1, single byte:
  - Stimulus: `data` = 0xA5 with a one-cycle valid.
  - Required `tx` bit sequence at T-cycle spacing: 0, 1,0,1,0,0,1,0,1, 1.
  - `ready` returns 1 exactly 41 cycles after the first tick following the handshake (N = 10, so t + 41).
- Even parity (`PARITY` = 1), byte 0xA5: parity bit is 0. Odd parity (`PARITY` = 2): parity bit is 1. Both frames are 11 bits.
- `STOP_BITS` = 2, back-to-back:
  - Stimulus: `valid` held high with bytes 0x00 then 0xFF.
  - Required: second start bit begins no earlier than 2T after the first frame's stop begins; no dropped or duplicated byte.
- Tick coincident with the handshake: the tick is ignored; `tx` falls one cycle after the next tick (T cycles later).
- Reset mid-DATA:
  - Stimulus: assert `rst` during bit 3.
  - Required: `tx` goes to 1 the same cycle; after release `ready` = 1, `busy` = 0, and no further low bits appear.
- `DATA_BITS` = 5, byte 0x13: `tx` sequence is 0, 1,1,0,0,1, 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Frame states and parity mode encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_tx.sv
// Asynchronous serial transmitter paced by an external baud enable.
// Bytes arrive on a valid/ready handshake; tx is registered, idle high.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end

    uart_state_t          state;
    logic [DATA_BITS-1:0] sreg;
    logic [CW-1:0]        bcnt;
    logic                 scnt;
    logic                 par;

    assign ready = (state == IDLE) && !rst;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tx    <= 1'b1;
            sreg  <= '0;
            bcnt  <= '0;
            scnt  <= 1'b0;
            par   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A tick coinciding with the handshake is deliberately ignored.
                    if (valid) begin
                        sreg  <= data;
                        par   <= (^data) ^ (PARITY == PAR_ODD);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (tick) begin
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx    <= sreg[0];
                        sreg  <= {1'b0, sreg[DATA_BITS-1:1]};
                        bcnt  <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bcnt == LAST_BIT) begin
                            bcnt <= '0;
                            scnt <= 1'b0;
                            if (PARITY != PAR_NONE) begin
                                tx    <= par;
                                state <= PAR;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bcnt <= bcnt + 1'b1;
                            tx   <= sreg[0];
                            sreg <= {1'b0, sreg[DATA_BITS-1:1]};
                        end
                    end
                end
                PAR: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        scnt  <= 1'b0;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (scnt == LAST_STOP) begin
                            scnt  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            scnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: several parameterisations share clk, rst, tick.
// The selected instance is muxed onto common observation signals.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] tcnt = 2'd0;
    logic       tick;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    int         sel = 0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic [4:0] v, rdy, txs, bsy;
    logic       tx_m, ready_m, busy_m;

    always #5 clk = ~clk;

    // T = 4 baud enable, one clk wide
    always @(posedge clk) begin
        tcnt <= tcnt + 2'd1;
        cyc  <= cyc + 1;
    end
    assign tick = (tcnt == 2'd3);

    always_comb begin
        for (int i = 0; i < 5; i++) v[i] = valid && (sel == i);
    end
    assign tx_m    = txs[sel];
    assign ready_m = rdy[sel];
    assign busy_m  = bsy[sel];

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .tick(tick), .data(data), .valid(v[0]),
        .ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .tick(tick), .data(data), .valid(v[1]),
        .ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .tick(tick), .data(data), .valid(v[2]),
        .ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]));
    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .tick(tick), .data(data), .valid(v[3]),
        .ready(rdy[3]), .tx(txs[3]), .busy(bsy[3]));
    uart_tx #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_5n1 (
        .clk(clk), .rst(rst), .tick(tick), .data(data[4:0]), .valid(v[4]),
        .ready(rdy[4]), .tx(txs[4]), .busy(bsy[4]));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake from a negedge; returns the edge number of the handshake.
    task automatic send(input logic [7:0] d, output int hs);
        data  = d;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        hs = cyc;
        chk("accept_busy", busy_m, 1'b1);
        chk("accept_ready", ready_m, 1'b0);
        chk("accept_tx", tx_m, 1'b1);
    endtask

    // Stops at the negedge just before the next tick edge; returns that edge.
    task automatic wait_tick(output int te);
        int g = 0;
        while (!tick && g < 16) begin
            @(negedge clk);
            g++;
        end
        te = cyc + 1;
        if (!tick) chk("tick_timeout", 1'b0, 1'b1);
    endtask

    // Samples each bit mid-period; checks exact ready/busy edges at frame end.
    task automatic frame_bits(input string tag, input int nbits,
                              input logic [15:0] exp);
        @(negedge clk);
        for (int k = 0; k < nbits; k++) begin
            repeat (2) @(negedge clk);
            chk($sformatf("%s_bit%0d", tag, k), tx_m, exp[k]);
            @(negedge clk);
            if (k == nbits - 1) begin
                chk({tag, "_ready_early"}, ready_m, 1'b0);
                chk({tag, "_busy_last"}, busy_m, 1'b1);
            end
            @(negedge clk);
        end
        chk({tag, "_ready_end"}, ready_m, 1'b1);
        chk({tag, "_busy_end"}, busy_m, 1'b0);
    endtask

    initial begin
        int hs, t1, t2, lows, highs;

        repeat (3) @(negedge clk);
        chk("rst_tx", txs, 5'b11111);
        chk("rst_busy", bsy, 5'b00000);
        chk("rst_ready", rdy, 5'b00000);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", rdy, 5'b11111);
        chk("rel_tx", txs, 5'b11111);

        // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1
        sel = 0;
        send(8'hA5, hs);
        wait_tick(t1);
        frame_bits("8n1", 10, 16'b0000_0011_0100_1010);

        // even parity 0xA5: parity 0
        sel = 1;
        send(8'hA5, hs);
        wait_tick(t1);
        frame_bits("8e1", 11, 16'b0000_0101_0100_1010);

        // odd parity 0xA5: parity 1
        sel = 2;
        send(8'hA5, hs);
        wait_tick(t1);
        frame_bits("8o1", 11, 16'b0000_0111_0100_1010);

        // 5 data bits, 0x13: 0,1,1,0,0,1,1
        sel = 4;
        send(8'h13, hs);
        wait_tick(t1);
        frame_bits("5n1", 7, 16'b0000_0000_0110_0110);

        // tick coincident with the handshake must be ignored
        sel = 0;
        for (int i = 0; i < 8 && !tick; i++) @(negedge clk);
        chk("coinc_tick_found", tick, 1'b1);
        send(8'hA5, hs);
        wait_tick(t1);
        chk("coinc_gap", t1 - hs, 4);
        frame_bits("coinc", 10, 16'b0000_0011_0100_1010);

        // two stop bits, valid held high: 0x00 then 0xFF
        sel = 3;
        data  = 8'h00;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data = 8'hFF;
        chk("b2b_busy0", busy_m, 1'b1);
        wait_tick(t1);
        frame_bits("b2b0", 11, 16'b0000_0110_0000_0000);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        chk("b2b_accept1", busy_m, 1'b1);
        wait_tick(t2);
        chk("b2b_gap", (t2 - (t1 + 36)) >= 8, 1'b1);
        frame_bits("b2b1", 11, 16'b0000_0111_1111_1110);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_m) highs++;
        end
        chk("b2b_no_dup", highs, 0);

        // reset during data bit 3 aborts the frame
        sel = 0;
        send(8'h00, hs);
        wait_tick(t1);
        repeat (18) @(negedge clk);
        chk("rstmid_bit3", tx_m, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstmid_tx", tx_m, 1'b1);
        chk("rstmid_ready", ready_m, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_rel_ready", ready_m, 1'b1);
        chk("rstmid_rel_busy", busy_m, 1'b0);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!tx_m) lows++;
        end
        chk("rstmid_no_resume", lows, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
